// File: rtl/lif_neuron_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lif_neuron_seq: leaky integrate-and-fire neuron, N_IN weighted spike |
// | inputs, internal step sequencer, saturation and refractory period.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module lif_neuron_seq #(
  parameter int N_IN      = 4,
  parameter int DATA_BITS = 4,
  parameter int POT_BITS  = 8,
  parameter int THOLD     = 8,
  parameter int LEAK      = 1,
  parameter int REFRAC    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_IN-1:0]           spikes_in,
  input  logic [N_IN*DATA_BITS-1:0] weights_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      spike_out,
  output logic                      out_valid,
  output logic [POT_BITS-1:0]       potential,
  output logic                      refrac_active
);

  localparam int c_idx_w = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int c_cnt_w = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(N_IN - 1);
  localparam logic [c_cnt_w-1:0]  c_refrac   = c_cnt_w'(REFRAC);
  localparam logic [POT_BITS-1:0] c_leak     = POT_BITS'(LEAK);
  localparam logic [POT_BITS:0]   c_thold    = (POT_BITS + 1)'(THOLD);
  localparam logic [POT_BITS-1:0] c_pot_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_accept;
  logic [c_idx_w-1:0]        r_idx;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [N_IN-1:0]           r_spikes;
  logic [N_IN*DATA_BITS-1:0] r_weights;
  logic [POT_BITS-1:0]       r_pot;
  logic                      r_spike_out;
  logic                      r_out_valid;

  logic                      w_refrac;
  logic [DATA_BITS-1:0]      w_weight;
  logic [POT_BITS:0]         w_sum;
  logic [POT_BITS-1:0]       w_sat;
  logic [POT_BITS-1:0]       w_leaked;
  logic                      w_fire;

  // The refractory count only changes in EVAL, so it is stable for the whole step.
  assign w_refrac = (r_cnt != '0);
  assign w_weight = r_weights[r_idx*DATA_BITS +: DATA_BITS];
  assign w_sum    = {1'b0, r_pot} + (POT_BITS + 1)'(w_weight);
  assign w_sat    = w_sum[POT_BITS] ? c_pot_max : w_sum[POT_BITS-1:0];
  assign w_leaked = (r_pot > c_leak) ? (r_pot - c_leak) : '0;
  assign w_fire   = ({1'b0, r_pot} > c_thold);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        if (r_idx == c_last_idx) w_next = S_EVAL;
      end
      S_EVAL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_spikes    <= '0;
      r_weights   <= '0;
      r_pot       <= '0;
      r_spike_out <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_spikes  <= spikes_in;
            r_weights <= weights_in;
            r_idx     <= '0;
            if (!w_refrac) r_pot <= w_leaked;
          end
        end
        S_ACCUM: begin
          if (r_spikes[r_idx] && !w_refrac) r_pot <= w_sat;
          r_idx <= r_idx + 1'b1;
        end
        S_EVAL: begin
          r_out_valid <= 1'b1;
          if (w_refrac) begin
            r_spike_out <= 1'b0;
            r_cnt       <= r_cnt - 1'b1;
          end else if (w_fire) begin
            r_spike_out <= 1'b1;
            r_pot       <= '0;
            r_cnt       <= c_refrac;
          end else begin
            r_spike_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign spike_out     = r_spike_out;
  assign out_valid     = r_out_valid;
  assign potential     = r_pot;
  assign refrac_active = w_refrac;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lif_neuron_seq: directed checks of lif_neuron_seq (default, high  |
// | threshold, single-input no-refractory instances). Revision: 1.0      |
// +----------------------------------------------------------------------+
module tb_lif_neuron_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [3:0]  sp_a = '0, sp_b = '0;
  logic [15:0] w_a = '0, w_b = '0;
  logic        v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic        sp_c = 1'b0;
  logic [3:0]  w_c = '0;

  logic       rdy_a, so_a, ov_a, ra_a;
  logic       rdy_b, so_b, ov_b, ra_b;
  logic       rdy_c, so_c, ov_c, ra_c;
  logic [7:0] pot_a, pot_b, pot_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lif_neuron_seq dut_a (
    .clk(clk), .rst(rst), .spikes_in(sp_a), .weights_in(w_a), .in_valid(v_a),
    .in_ready(rdy_a), .spike_out(so_a), .out_valid(ov_a), .potential(pot_a),
    .refrac_active(ra_a)
  );

  lif_neuron_seq #(.THOLD(255)) dut_b (
    .clk(clk), .rst(rst), .spikes_in(sp_b), .weights_in(w_b), .in_valid(v_b),
    .in_ready(rdy_b), .spike_out(so_b), .out_valid(ov_b), .potential(pot_b),
    .refrac_active(ra_b)
  );

  lif_neuron_seq #(.N_IN(1), .REFRAC(0)) dut_c (
    .clk(clk), .rst(rst), .spikes_in(sp_c), .weights_in(w_c), .in_valid(v_c),
    .in_ready(rdy_c), .spike_out(so_c), .out_valid(ov_c), .potential(pot_c),
    .refrac_active(ra_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy_a : ((d == 1) ? rdy_b : rdy_c);
  endfunction

  function automatic logic ov_of(input int d);
    return (d == 0) ? ov_a : ((d == 1) ? ov_b : ov_c);
  endfunction

  task automatic set_valid(input int d, input logic v);
    case (d)
      0:       v_a = v;
      1:       v_b = v;
      default: v_c = v;
    endcase
  endtask

  // Runs one handshake on instance d; lat = clock edges from accept to out_valid.
  task automatic step(input int d, input logic [3:0] sp, input logic [15:0] w, output int lat);
    int guard = 0;
    case (d)
      0:       begin sp_a = sp;    w_a = w;      end
      1:       begin sp_b = sp;    w_b = w;      end
      default: begin sp_c = sp[0]; w_c = w[3:0]; end
    endcase
    while (!rdy_of(d) && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    set_valid(d, 1'b1);
    @(posedge clk); #1;
    set_valid(d, 1'b0);
    lat = 0;
    while (!ov_of(d) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int seen;
    int exp_b[6];
    exp_b = '{60, 119, 178, 237, 255, 255};

    repeat (2) @(posedge clk);
    #1;
    check("rst_pot", pot_a, 0);
    check("rst_ov", ov_a, 0);
    check("rst_so", so_a, 0);
    check("rst_refrac", ra_a, 0);
    check("rst_ready", rdy_a, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Default instance: integrate, fire, refractory, recover.
    step(0, 4'b0011, 16'h3333, lat);
    check("a1_lat", lat, 5);
    check("a1_so", so_a, 0);
    check("a1_pot", pot_a, 6);
    step(0, 4'b0011, 16'h3333, lat);
    check("a2_so", so_a, 1);
    check("a2_pot", pot_a, 0);
    check("a2_refrac", ra_a, 1);
    step(0, 4'b1111, 16'h3333, lat);
    check("a3_so", so_a, 0);
    check("a3_pot", pot_a, 0);
    check("a3_refrac", ra_a, 1);
    check("a3_lat", lat, 5);
    step(0, 4'b1111, 16'h3333, lat);
    check("a4_so", so_a, 0);
    check("a4_pot", pot_a, 0);
    check("a4_refrac", ra_a, 0);
    step(0, 4'b1111, 16'h3333, lat);
    check("a5_so", so_a, 1);
    check("a5_pot", pot_a, 0);

    // Continuous in_valid with inputs changed mid-step.
    pulse_reset();
    check("hs_refrac_clr", ra_a, 0);
    sp_a = 4'b0011; w_a = 16'h3333; v_a = 1'b1;
    @(posedge clk); #1;
    sp_a = 4'b1111; w_a = 16'hFFFF;
    check("hs_busy_ready", rdy_a, 0);
    lat = 0;
    while (!ov_a && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("hs1_lat", lat, 5);
    check("hs1_pot", pot_a, 6);
    check("hs1_so", so_a, 0);
    check("hs1_ready", rdy_a, 1);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ov_a && lat < 20);
    v_a = 1'b0;
    check("hs2_period", lat, 6);
    check("hs2_so", so_a, 1);
    check("hs2_pot", pot_a, 0);

    // Asynchronous reset in the middle of ACCUM.
    pulse_reset();
    sp_a = 4'b0011; w_a = 16'h00FF; v_a = 1'b1;
    @(posedge clk); #1;
    v_a = 1'b0;
    @(posedge clk); #1;
    check("mr_pot_e1", pot_a, 15);
    @(posedge clk); #1;
    check("mr_pot_e2", pot_a, 30);
    rst = 1'b0;
    #1;
    check("mr_pot_rst", pot_a, 0);
    check("mr_ov_rst", ov_a, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov_a) seen++;
    end
    check("mr_no_pulse", seen, 0);
    check("mr_ready", rdy_a, 1);
    step(0, 4'b0011, 16'h3333, lat);
    check("mr_next_pot", pot_a, 6);

    // High threshold instance: saturation and leak floor.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 4'b1111, 16'hFFFF, lat);
      check($sformatf("sat%0d_pot", i), pot_b, exp_b[i]);
      check($sformatf("sat%0d_so", i), so_b, 0);
    end
    step(1, 4'b0000, 16'hFFFF, lat);
    check("sat_leak_pot", pot_b, 254);
    pulse_reset();
    step(1, 4'b0000, 16'hFFFF, lat);
    check("floor_pot", pot_b, 0);
    check("floor_so", so_b, 0);

    // Single-input instance without refractory period.
    step(2, 4'b0001, 16'h0009, lat);
    check("c1_lat", lat, 2);
    check("c1_so", so_c, 1);
    check("c1_pot", pot_c, 0);
    check("c1_refrac", ra_c, 0);
    step(2, 4'b0001, 16'h0009, lat);
    check("c2_lat", lat, 2);
    check("c2_so", so_c, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
